// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the write-back port arbiter.
package wb_arb_pkg;

   localparam int unsigned BUF_DEPTH_C = 2;
   localparam int unsigned RW_W        = 5;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned CNT_W       = $clog2(BUF_DEPTH_C + 1);

   typedef struct packed {
      logic [RW_W-1:0]   Rw;
      logic [DATA_W-1:0] data;
      logic              fp;
   } wb_entry_t;

   // GPR 0 is hardwired; writes to it are swallowed.
   function automatic logic is_gpr0(input wb_entry_t e);
      return (!e.fp) && (e.Rw == '0);
   endfunction

   function automatic logic same_dest(input wb_entry_t a, input wb_entry_t b);
      return (a.Rw == b.Rw) && (a.fp == b.fp);
   endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle: integer pipe, multi-cycle unit, and register-file write side.
interface wb_port_arbiter_if;
   import wb_arb_pkg::*;

   logic              int_we;
   logic [RW_W-1:0]   int_Rw;
   logic [DATA_W-1:0] int_data;
   logic              int_fp;
   logic              mc_valid;
   logic [RW_W-1:0]   mc_Rw;
   logic [DATA_W-1:0] mc_data;
   logic              mc_fp;
   logic              mc_ready;
   logic              reg_we_out;
   logic              freg_we_out;
   logic [RW_W-1:0]   Rw_out;
   logic [DATA_W-1:0] BUS_W;
   logic [DATA_W-1:0] FBUS_W;
   logic              stall_req;

   modport slave (
      input  int_we, int_Rw, int_data, int_fp,
      input  mc_valid, mc_Rw, mc_data, mc_fp,
      output mc_ready, reg_we_out, freg_we_out, Rw_out, BUS_W, FBUS_W, stall_req
   );

   modport master (
      output int_we, int_Rw, int_data, int_fp,
      output mc_valid, mc_Rw, mc_data, mc_fp,
      input  mc_ready, reg_we_out, freg_we_out, Rw_out, BUS_W, FBUS_W, stall_req
   );

endinterface

// File: rtl/wb_fifo2.sv
// Two-entry holding FIFO for multi-cycle results: push, pop oldest, squash by index.
module wb_fifo2
   import wb_arb_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  wb_entry_t              push_data,
   input  logic                   pop,
   input  logic [BUF_DEPTH_C-1:0] squash,
   output wb_entry_t              head,
   output wb_entry_t              second,
   output logic [CNT_W-1:0]       count,
   output logic                   full,
   output logic                   empty
);

   wb_entry_t        mem     [BUF_DEPTH_C];
   wb_entry_t        mem_nxt [BUF_DEPTH_C];
   logic [CNT_W-1:0] cnt, cnt_nxt, kept;
   logic             keep0, keep1;

   // Remove popped/squashed entries, compact survivors to the front, then append.
   always_comb begin
      mem_nxt = mem;
      kept    = '0;
      keep0   = (cnt != '0) && !(pop || squash[0]);
      keep1   = (cnt == CNT_W'(BUF_DEPTH_C)) && !squash[1];
      unique case ({keep1, keep0})
         2'b11:   kept = CNT_W'(2);
         2'b01:   kept = CNT_W'(1);
         2'b10: begin
            mem_nxt[0] = mem[1];
            kept       = CNT_W'(1);
         end
         default: kept = '0;
      endcase
      if (push) begin
         if (kept == '0) mem_nxt[0] = push_data;
         else            mem_nxt[1] = push_data;
      end
      cnt_nxt = kept + CNT_W'(push);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         mem <= '{default: '0};
      end else begin
         cnt <= cnt_nxt;
         mem <= mem_nxt;
      end
   end

   assign head   = mem[0];
   assign second = mem[1];
   assign count  = cnt;
   assign full   = (cnt == CNT_W'(BUF_DEPTH_C));
   assign empty  = (cnt == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Single write-port arbiter between the integer pipe and a multi-cycle unit.
// Define WB_ARB_PERF_EN to add stall/full performance counters.
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned BUF_DEPTH    = 2
) (
   input  logic clk,
   input  logic reset,
   wb_port_arbiter_if.slave bus
`ifdef WB_ARB_PERF_EN
   ,
   output logic [15:0] perf_stall_cnt,
   output logic [15:0] perf_full_cnt
`endif
);

   localparam int unsigned DEPTH = (BUF_DEPTH == BUF_DEPTH_C) ? BUF_DEPTH : BUF_DEPTH_C;
   localparam int unsigned SC_W  = 8;
   localparam logic [SC_W-1:0] LIMIT_V = SC_W'(STARVE_LIMIT);

   wb_entry_t        int_e, mc_e, wr_e, head, second;
   logic [CNT_W-1:0] count, removed;
   logic             full, empty;
   logic             stall, int_go, pop, ready, accept, bypass, push, wr_v, held;
   logic [DEPTH-1:0] squash;
   logic [SC_W-1:0]  starve_cnt, starve_nxt;

   wb_fifo2 u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (mc_e),
      .pop       (pop),
      .squash    (squash),
      .head      (head),
      .second    (second),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   // Write selection: starvation stall > integer pipe > oldest buffered > bypass.
   always_comb begin
      int_e  = '{Rw: bus.int_Rw, data: bus.int_data, fp: bus.int_fp};
      mc_e   = '{Rw: bus.mc_Rw,  data: bus.mc_data,  fp: bus.mc_fp};
      stall  = !reset && !empty && (starve_cnt == LIMIT_V);
      int_go = !reset && !stall && bus.int_we;
      pop    = !reset && !empty && (stall || !bus.int_we);
      // A same-destination integer write is younger, so the buffered result is dead.
      squash[0] = int_go && !empty && same_dest(head, int_e);
      squash[1] = int_go && full   && same_dest(second, int_e);
      ready  = !reset && (!full || pop || (|squash));
      accept = bus.mc_valid && ready;
      bypass = accept && empty && !int_go;
      push   = accept && !bypass;

      wr_e = '0;
      if (int_go)      wr_e = int_e;
      else if (pop)    wr_e = head;
      else if (bypass) wr_e = mc_e;
      wr_v = (int_go || pop || bypass) && !is_gpr0(wr_e);

      removed = CNT_W'(pop) + CNT_W'(squash[0]) + CNT_W'(squash[1]);
      held    = push || (count > removed);
      if (pop || !held)              starve_nxt = '0;
      else if (starve_cnt == LIMIT_V) starve_nxt = starve_cnt;
      else                            starve_nxt = starve_cnt + SC_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) starve_cnt <= '0;
      else       starve_cnt <= starve_nxt;
   end

   assign bus.mc_ready    = ready;
   assign bus.stall_req   = stall;
   assign bus.reg_we_out  = wr_v && !wr_e.fp;
   assign bus.freg_we_out = wr_v && wr_e.fp;
   assign bus.Rw_out      = wr_v ? wr_e.Rw : '0;
   assign bus.BUS_W       = (wr_v && !wr_e.fp) ? wr_e.data : '0;
   assign bus.FBUS_W      = (wr_v && wr_e.fp)  ? wr_e.data : '0;

`ifdef WB_ARB_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stall_cnt <= '0;
         perf_full_cnt  <= '0;
      end else begin
         if (stall && (perf_stall_cnt != '1))
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
         if (bus.mc_valid && !ready && (perf_full_cnt != '1))
            perf_full_cnt <= perf_full_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised + directed bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;
   import wb_arb_pkg::*;

   localparam int unsigned LIMIT = 8;

   logic clk = 1'b0;
   logic reset;
   logic rst_drv;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   wb_port_arbiter_if bus();

`ifdef WB_ARB_PERF_EN
   logic [15:0] perf_stall_cnt, perf_full_cnt;
   wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .BUF_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .perf_stall_cnt(perf_stall_cnt), .perf_full_cnt(perf_full_cnt));
`else
   wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .BUF_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .bus(bus));
`endif

   // Reference state: pending multi-cycle results in arrival order, and how long they have waited.
   wb_entry_t   mq[$];
   int unsigned mwait;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs after the edge, predict, then compare mid-cycle.
   task automatic step(input logic iwe, input logic [4:0] irw, input logic [31:0] idat,
                       input logic ifp, input logic mv, input logic [4:0] mrw,
                       input logic [31:0] mdat, input logic mfp);
      wb_entry_t ie, me, w;
      logic wr, drained, e_stall, e_ready, gpr, fpr;
      @(posedge clk);
      #1;
      reset        = rst_drv;
      bus.int_we   = iwe;  bus.int_Rw = irw; bus.int_data = idat; bus.int_fp = ifp;
      bus.mc_valid = mv;   bus.mc_Rw  = mrw; bus.mc_data  = mdat; bus.mc_fp  = mfp;
      #3;
      ie = '{Rw: irw, data: idat, fp: ifp};
      me = '{Rw: mrw, data: mdat, fp: mfp};
      w = '0; wr = 1'b0; drained = 1'b0; e_stall = 1'b0; e_ready = 1'b0;
      if (rst_drv) begin
         mq.delete();
         mwait = 0;
      end else begin
         e_stall = (mwait == LIMIT) && (mq.size() != 0);
         if (e_stall) begin
            w = mq.pop_front(); wr = 1'b1; drained = 1'b1;
         end else if (iwe) begin
            w = ie; wr = 1'b1;
            for (int i = int'(mq.size()) - 1; i >= 0; i--)
               if (mq[i].Rw == irw && mq[i].fp == ifp) mq.delete(i);
         end else if (mq.size() != 0) begin
            w = mq.pop_front(); wr = 1'b1; drained = 1'b1;
         end
         e_ready = (mq.size() < 2);
         if (mv && e_ready) begin
            if (!wr) begin w = me; wr = 1'b1; end
            else mq.push_back(me);
         end
         if (drained || mq.size() == 0) mwait = 0;
         else if (mwait < LIMIT)        mwait++;
      end
      gpr = wr && !w.fp && (w.Rw != 5'd0);
      fpr = wr && w.fp;
      check("reg_we",    32'(bus.reg_we_out),  32'(gpr));
      check("freg_we",   32'(bus.freg_we_out), 32'(fpr));
      check("Rw_out",    32'(bus.Rw_out),      (gpr || fpr) ? 32'(w.Rw) : 32'd0);
      check("BUS_W",     bus.BUS_W,            gpr ? w.data : 32'd0);
      check("FBUS_W",    bus.FBUS_W,           fpr ? w.data : 32'd0);
      check("stall_req", 32'(bus.stall_req),   32'(e_stall));
      check("mc_ready",  32'(bus.mc_ready),    32'(e_ready));
      check("one_write", 32'(bus.reg_we_out & bus.freg_we_out), 32'd0);
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
   endtask

   initial begin
      mwait   = 0;
      rst_drv = 1'b1;
      reset   = 1'b1;
      bus.int_we = 1'b0; bus.int_Rw = '0; bus.int_data = '0; bus.int_fp = 1'b0;
      bus.mc_valid = 1'b0; bus.mc_Rw = '0; bus.mc_data = '0; bus.mc_fp = 1'b0;

      // Reset state, including an integer request that must not leak through.
      step(1'b1, 5'd4, 32'h1111_2222, 1'b0, 1'b1, 5'd6, 32'h3333_4444, 1'b0);
      check("rst_ready", 32'(bus.mc_ready), 32'd0);
      check("rst_we",    32'(bus.reg_we_out), 32'd0);
      idle();
      rst_drv = 1'b0;
      idle();
      check("post_rst_ready", 32'(bus.mc_ready), 32'd1);

      // Integer write goes straight to the GPR file.
      step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      check("int_we",   32'(bus.reg_we_out), 32'd1);
      check("int_rw",   32'(bus.Rw_out),     32'd5);
      check("int_data", bus.BUS_W,           32'hDEAD_BEEF);

      // Zero-latency bypass to the FPR file with an empty buffer.
      step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd3, 32'h3F80_0000, 1'b1);
      check("byp_fwe",  32'(bus.freg_we_out), 32'd1);
      check("byp_data", bus.FBUS_W,           32'h3F80_0000);
      idle();
      check("byp_empty", 32'(bus.reg_we_out | bus.freg_we_out), 32'd0);

      // Buffer fills behind integer traffic, then drains oldest first.
      step(1'b1, 5'd10, 32'hA0, 1'b0, 1'b1, 5'd20, 32'hB0, 1'b0);
      step(1'b1, 5'd11, 32'hA1, 1'b0, 1'b1, 5'd21, 32'hB1, 1'b0);
      step(1'b1, 5'd12, 32'hA2, 1'b0, 1'b1, 5'd22, 32'hB2, 1'b0);
      check("full_ready", 32'(bus.mc_ready), 32'd0);
      idle();
      check("drain0", 32'(bus.Rw_out), 32'd20);
      idle();
      check("drain1", 32'(bus.Rw_out), 32'd21);
      idle();

      // Same-destination integer write kills the buffered result.
      step(1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 5'd7, 32'h777, 1'b0);
      step(1'b1, 5'd7, 32'h1234, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      check("waw_rw",   32'(bus.Rw_out), 32'd7);
      check("waw_data", bus.BUS_W,       32'h1234);
      idle();
      check("waw_gone", 32'(bus.reg_we_out | bus.freg_we_out), 32'd0);

      // Starvation: entry accepted in cycle 0 is forced out in cycle LIMIT.
      step(1'b1, 5'd1, 32'h11, 1'b0, 1'b1, 5'd2, 32'hAA, 1'b0);
      for (int c = 1; c <= 9; c++) begin
         step(1'b1, 5'd1, 32'h11, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
         check($sformatf("starve_stall_c%0d", c), 32'(bus.stall_req), (c == 8) ? 32'd1 : 32'd0);
         if (c == 8) check("starve_rw", 32'(bus.Rw_out), 32'd2);
         if (c == 9) check("resume_rw", 32'(bus.Rw_out), 32'd1);
      end
      idle();

      // GPR 0 swallowed, FPR 0 still written.
      step(1'b1, 5'd0, 32'hCAFE, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      check("gpr0_we", 32'(bus.reg_we_out), 32'd0);
      check("gpr0_bus", bus.BUS_W, 32'd0);
      step(1'b1, 5'd0, 32'hBEEF, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      check("fpr0_we", 32'(bus.freg_we_out), 32'd1);

      // Reset with two buffered entries discards them.
      step(1'b1, 5'd13, 32'hC0, 1'b0, 1'b1, 5'd14, 32'hD0, 1'b0);
      step(1'b1, 5'd13, 32'hC1, 1'b0, 1'b1, 5'd15, 32'hD1, 1'b0);
      rst_drv = 1'b1;
      step(1'b1, 5'd6, 32'hE0, 1'b0, 1'b1, 5'd16, 32'hE1, 1'b1);
      check("midrst_we",  32'(bus.reg_we_out), 32'd0);
      check("midrst_bus", bus.BUS_W,           32'd0);
      idle();
      rst_drv = 1'b0;
      idle();
      check("midrst_ready", 32'(bus.mc_ready), 32'd1);
      check("midrst_nowr",  32'(bus.reg_we_out | bus.freg_we_out), 32'd0);
      idle();
      check("midrst_nowr2", 32'(bus.reg_we_out | bus.freg_we_out), 32'd0);

      // Random traffic with narrow register ranges to provoke squashes and starvation.
      for (int n = 0; n < 3000; n++) begin
         int unsigned p_int;
         p_int   = (n < 1500) ? 50 : 90;
         rst_drv = ($urandom_range(0, 299) == 0);
         step(1'($urandom_range(0, 99) < p_int), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: consecutive cycles a buffered multi-cycle result may wait before the integer pipe is stalled (range 2..255).
REQ-002 SHALL have parameter BUF_DEPTH, default 2: holding-buffer entries for multi-cycle results (fixed at 2 in this revision).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port int_we  input  1  the integer pipe (MEM/WB) requests a register write this cycle.
REQ-006 SHALL have ports int_Rw  input  5, int_data  input  32, int_fp  input  1: integer-pipe destination, value, and target file (1 = FPR, 0 = GPR).
REQ-007 SHALL have port mc_valid  input  1  the multi-cycle unit (FPU/mul/div) presents a result.
REQ-008 SHALL have ports mc_Rw  input  5, mc_data  input  32, mc_fp  input  1: multi-cycle destination, value, and target file.
REQ-009 SHALL have port mc_ready  output  1  a result is accepted when mc_valid and mc_ready are both 1.
REQ-010 SHALL have ports reg_we_out  output  1, freg_we_out  output  1: GPR and FPR write enables.
REQ-011 SHALL have ports Rw_out  output  5, BUS_W  output  32, FBUS_W  output  32: shared write address and the GPR/FPR write data.
REQ-012 SHALL have port stall_req  output  1  freezes MEM/WB and injects a WB bubble.

Function
REQ-013 SHALL perform at most one write per cycle; reg_we_out and freg_we_out are never both 1.
REQ-014 SHALL give priority to int_we=1 when stall_req=0; the write is combinational, same cycle, to the file selected by int_fp.
REQ-015 SHALL, when no integer write occurs, write the oldest buffer entry; if the buffer is empty and a handshake occurs, SHALL write mc_data straight through in the same cycle (zero-latency bypass, not buffered).
REQ-016 SHALL buffer an accepted multi-cycle result that is not written in its acceptance cycle, in arrival order.
REQ-017 SHALL drive mc_ready = 1 when the buffer is not full, or when it is full and an entry drains this cycle.
REQ-018 SHALL drop a buffered entry whose (Rw, fp) equals the integer write's (int_Rw, int_fp) in the same cycle, since the integer write is younger in program order (WAW squash); the squashed entry frees its slot in that cycle.
REQ-019 SHALL suppress every write to GPR 0; such requests complete but leave all write enables at 0.
REQ-020 SHALL count consecutive cycles in which the buffer is non-empty and no entry drains, saturating at STARVE_LIMIT.
REQ-021 SHALL clear the starvation counter on any drain, and when the buffer is empty.
REQ-022 SHALL assert stall_req while the counter equals STARVE_LIMIT; int_we is then ignored (upstream holds and re-presents it), the oldest entry drains, and the counter clears next cycle.
REQ-023 SHALL drive Rw_out, BUS_W and FBUS_W to 0 in cycles with no write.

Reset
REQ-024 SHALL, while reset=1, empty the buffer, clear the starvation counter, and force reg_we_out=0, freg_we_out=0, stall_req=0, mc_ready=0, Rw_out=0, BUS_W=0, FBUS_W=0.
REQ-025 SHALL discard buffered results on reset mid-operation; mc_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-026 SHALL, with WB_ARB_PERF_EN defined, add outputs perf_stall_cnt and perf_full_cnt (16-bit, saturating, cleared by reset), counting stall_req cycles and cycles with mc_valid=1 and mc_ready=0.
REQ-027 SHALL, without WB_ARB_PERF_EN, omit those ports and counters entirely, with all other behaviour identical.

Structure
REQ-028 SHALL take struct wb_entry_t (Rw[5], data[32], fp[1]) and constant BUF_DEPTH_C=2 from shared package wb_arb_pkg.
REQ-029 SHALL implement the buffer as sub-module wb_fifo2: a 2-entry FIFO with push, pop and squash-by-index, and full/empty/count outputs.

Verification
REQ-030 SHALL cover: int_we=1, int_Rw=5, int_data=0xDEADBEEF, int_fp=0 -> reg_we_out=1, Rw_out=5, BUS_W=0xDEADBEEF in the same cycle.
REQ-031 SHALL cover: empty buffer, int_we=0, mc_valid=1, mc_Rw=3, mc_fp=1, mc_data=0x3F800000 -> freg_we_out=1, FBUS_W=0x3F800000 in the same cycle, buffer stays empty.
REQ-032 SHALL cover: int_we=1 for 3 cycles with mc_valid=1 -> 2 results accepted, mc_ready=0 in cycle 3, both results drain FIFO-order once int_we=0.
REQ-033 SHALL cover: buffered mc entry (Rw=7, fp=0) plus int_we=1, int_Rw=7, int_fp=0 -> only the integer value is written, and that entry never appears.
REQ-034 SHALL cover: one buffered entry, int_we held 1, STARVE_LIMIT=8 -> stall_req=1 on cycle 8, entry drains, stall_req=0 on cycle 9.
REQ-035 SHALL cover: reset asserted with 2 buffered entries -> all outputs 0 immediately, no buffered write ever occurs, mc_ready=1 after release.
